alu_bit_slice: RTL and testbench
================================

Name: alu_bit_slice

Overview:
- Single-bit ALU slice with registered outputs.
- Performs MOV, NOT, ADD, SUB, OR and AND on 1-bit operands, with carry/borrow in and out.
- Intended as the replicated cell of a ripple-chained N-bit ALU datapath.
- All results are captured on the clock edge when the input is qualified by in_valid.

Parameters:
- OUT_REG, default 1: 1 = r/c_out/out_valid are registered (1-cycle latency); 0 = combinational passthrough of the next-state values, with clk/rst unused.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands/opcode are valid this cycle
- a  input  1  operand A
- b  input  1  operand B
- c_in  input  1  carry-in (ADD) / borrow-in (SUB); ignored by other ops
- ALUOp  input  3  operation select
- r  output  1  result bit
- c_out  output  1  carry-out (ADD) / borrow-out (SUB); 0 for other ops
- out_valid  output  1  r/c_out hold a freshly computed result

Behaviour:
- Single clock domain (clk); rst is asynchronous and active-high.
- Reset: r=0, c_out=0, out_valid=0, applied immediately on rst assertion regardless of clk. First capture occurs on the first rising clk edge after rst deasserts.
- Opcode map (next-state values):
  - 000 MOV: r=a; c_out=0.
  - 001 NOT: r=~a; c_out=0.
  - 010 ADD (full adder): r=a^b^c_in; c_out=(a&b)|(a&c_in)|(b&c_in).
  - 011 SUB (full subtractor, a-b-c_in): r=a^b^c_in; c_out=(~a&b)|(~a&c_in)|(b&c_in), i.e. borrow-out. SUB is not two's-complement add.
  - 100 OR: r=a|b; c_out=0.
  - 101 AND: r=a&b; c_out=0.
  - 110, 111 reserved: r=0, c_out=0. Not an error; out_valid behaves normally.
- OUT_REG=1, rising clk edge with rst=0:
  - in_valid=1: r/c_out load the next-state values; out_valid<=1.
  - in_valid=0: r/c_out hold their previous values; out_valid<=0.
- Latency: exactly 1 cycle from inputs sampled with in_valid=1 to r/c_out/out_valid.
- Back-to-back in_valid every cycle is supported: full throughput, no stall, no backpressure.
- rst asserted mid-stream: any in-flight result is discarded and outputs return to 0 immediately.
- OUT_REG=0: r and c_out are the pure combinational functions above; out_valid=in_valid.
- Inputs that are X/Z are not specified; the bench drives only 0/1.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams/enum: OP_MOV=3'b000, OP_NOT=3'b001, OP_ADD=3'b010, OP_SUB=3'b011, OP_OR=3'b100, OP_AND=3'b101.
  - ALUOP_W=3.
- One natural sub-module, alu_bit_addsub: combinational full adder/subtractor.
  - inputs a, b, c_in, sub; outputs s, co.
  - sub selects carry vs borrow equation.
- The top contains the opcode mux, the output register and the valid pipeline.

Test Plan:
- Reset: assert rst between clk edges -> r=0, c_out=0, out_valid=0 immediately. Deassert rst; apply MOV a=1 in_valid=1 -> next edge r=1, c_out=0, out_valid=1.
- MOV/NOT sweep:
  - MOV (a,b,c_in)=(0,0,0)->r=0; (1,0,0)->r=1; (0,1,0)->r=0; (1,0,1)->r=1.
  - NOT a=1->r=0; a=0,b=1->r=1; a=0,b=0->r=1.
  - c_out=0 for all of these.
- ADD and SUB:
  - ADD (1,1,0)->r=0,c_out=1; (1,1,1)->r=1,c_out=1; (0,0,0)->r=0,c_out=0.
  - SUB (1,0,0)->r=1,c_out=0; (0,1,1)->r=0,c_out=1.
  - Exhaustive 8-combination check of both ops against the equations.
- OR/AND/reserved:
  - OR (1,0)->1, (1,1)->1, (0,0)->0.
  - AND (1,1)->1, (0,1)->0, (1,0)->0.
  - ALUOp=110 and 111 with a=b=c_in=1 -> r=0, c_out=0.
- Valid and hold: load ADD (1,1,0); drop in_valid and change inputs -> r=0/c_out=1 held, out_valid=0. Streaming with in_valid=1 every cycle -> a new result each cycle, 1-cycle latency.
- Mid-stream reset: assert rst asynchronously while out_valid=1 and r=1 -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings shared by the ALU bit slice
package alu_pkg;

    localparam int ALUOP_W = 3;

    localparam logic [ALUOP_W-1:0] OP_MOV = 3'b000;
    localparam logic [ALUOP_W-1:0] OP_NOT = 3'b001;
    localparam logic [ALUOP_W-1:0] OP_ADD = 3'b010;
    localparam logic [ALUOP_W-1:0] OP_SUB = 3'b011;
    localparam logic [ALUOP_W-1:0] OP_OR  = 3'b100;
    localparam logic [ALUOP_W-1:0] OP_AND = 3'b101;

endpackage

// File: rtl/alu_bit_addsub.sv
// rtl/alu_bit_addsub.sv - combinational one-bit full adder / full subtractor
module alu_bit_addsub (
    input  logic a,
    input  logic b,
    input  logic c_in,
    input  logic sub,
    output logic s,
    output logic co
);

    // Sum bit is identical for both; only the carry term differs.
    // Borrow-out uses the inverted minuend.
    logic a_eff;

    assign a_eff = sub ? ~a : a;
    assign s     = a ^ b ^ c_in;
    assign co    = (a_eff & b) | (a_eff & c_in) | (b & c_in);

endmodule

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - single-bit ALU slice with optional output register
module alu_bit_slice
    import alu_pkg::*;
#(
    parameter int OUT_REG = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               a,
    input  logic               b,
    input  logic               c_in,
    input  logic [ALUOP_W-1:0] ALUOp,
    output logic               r,
    output logic               c_out,
    output logic               out_valid
);

    logic as_s;
    logic as_co;
    logic r_nxt;
    logic c_nxt;

    alu_bit_addsub u_addsub (
        .a    (a),
        .b    (b),
        .c_in (c_in),
        .sub  (ALUOp == OP_SUB),
        .s    (as_s),
        .co   (as_co)
    );

    // Reserved encodings fall through to zero.
    always_comb begin
        r_nxt = 1'b0;
        c_nxt = 1'b0;
        case (ALUOp)
            OP_MOV: r_nxt = a;
            OP_NOT: r_nxt = ~a;
            OP_ADD, OP_SUB: begin
                r_nxt = as_s;
                c_nxt = as_co;
            end
            OP_OR:  r_nxt = a | b;
            OP_AND: r_nxt = a & b;
            default: begin
                r_nxt = 1'b0;
                c_nxt = 1'b0;
            end
        endcase
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic r_q;
            logic c_q;
            logic v_q;

            // Unqualified cycles keep the last result but drop valid.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= 1'b0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else begin
                    v_q <= in_valid;
                    if (in_valid) begin
                        r_q <= r_nxt;
                        c_q <= c_nxt;
                    end
                end
            end

            assign r         = r_q;
            assign c_out     = c_q;
            assign out_valid = v_q;
        end else begin : g_comb
            logic unused_clk_rst;

            assign unused_clk_rst = clk ^ rst;
            assign r              = r_nxt;
            assign c_out          = c_nxt;
            assign out_valid      = in_valid;
        end
    endgenerate

endmodule

// File: tb/tb_alu_bit_slice.sv
// tb/tb_alu_bit_slice.sv - directed self-checking bench for alu_bit_slice
module tb_alu_bit_slice;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       a;
    logic       b;
    logic       c_in;
    logic [2:0] ALUOp;
    logic       r;
    logic       c_out;
    logic       out_valid;

    int errors = 0;
    int checks = 0;

    logic [7:0] add_s_tbl;
    logic [7:0] add_c_tbl;
    logic [7:0] sub_c_tbl;

    alu_bit_slice #(.OUT_REG(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .ALUOp     (ALUOp),
        .r         (r),
        .c_out     (c_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic er, input logic ec, input logic ev);
        checks++;
        assert (r === er && c_out === ec && out_valid === ev)
        else begin
            errors++;
            $error("FAIL %s: r/c_out/out_valid=%b/%b/%b expected %b/%b/%b",
                   tag, r, c_out, out_valid, er, ec, ev);
        end
    endtask

    task automatic step(input logic [2:0] op, input logic ia, input logic ib,
                        input logic ic, input logic iv);
        @(negedge clk);
        ALUOp    = op;
        a        = ia;
        b        = ib;
        c_in     = ic;
        in_valid = iv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        add_s_tbl = 8'h96;
        add_c_tbl = 8'hE8;
        sub_c_tbl = 8'h8E;
        rst = 1'b1; in_valid = 1'b0; a = 1'b0; b = 1'b0; c_in = 1'b0; ALUOp = 3'b000;
        #7;
        chk("reset_state", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        step(3'b000, 1'b1, 1'b0, 1'b0, 1'b1); chk("first_mov", 1'b1, 1'b0, 1'b1);

        // MOV / NOT
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b1); chk("mov_000", 1'b0, 1'b0, 1'b1);
        step(3'b000, 1'b1, 1'b0, 1'b0, 1'b1); chk("mov_100", 1'b1, 1'b0, 1'b1);
        step(3'b000, 1'b0, 1'b1, 1'b0, 1'b1); chk("mov_010", 1'b0, 1'b0, 1'b1);
        step(3'b000, 1'b1, 1'b0, 1'b1, 1'b1); chk("mov_101", 1'b1, 1'b0, 1'b1);
        step(3'b001, 1'b1, 1'b0, 1'b0, 1'b1); chk("not_a1", 1'b0, 1'b0, 1'b1);
        step(3'b001, 1'b0, 1'b1, 1'b0, 1'b1); chk("not_a0b1", 1'b1, 1'b0, 1'b1);
        step(3'b001, 1'b0, 1'b0, 1'b0, 1'b1); chk("not_a0b0", 1'b1, 1'b0, 1'b1);

        // ADD / SUB directed
        step(3'b010, 1'b1, 1'b1, 1'b0, 1'b1); chk("add_110", 1'b0, 1'b1, 1'b1);
        step(3'b010, 1'b1, 1'b1, 1'b1, 1'b1); chk("add_111", 1'b1, 1'b1, 1'b1);
        step(3'b010, 1'b0, 1'b0, 1'b0, 1'b1); chk("add_000", 1'b0, 1'b0, 1'b1);
        step(3'b011, 1'b1, 1'b0, 1'b0, 1'b1); chk("sub_100", 1'b1, 1'b0, 1'b1);
        step(3'b011, 1'b0, 1'b1, 1'b1, 1'b1); chk("sub_011", 1'b0, 1'b1, 1'b1);

        // ADD / SUB full truth tables, index = {a,b,c_in}
        for (int i = 0; i < 8; i++) begin
            step(3'b010, i[2], i[1], i[0], 1'b1);
            chk($sformatf("add_tt%0d", i), add_s_tbl[i], add_c_tbl[i], 1'b1);
            step(3'b011, i[2], i[1], i[0], 1'b1);
            chk($sformatf("sub_tt%0d", i), add_s_tbl[i], sub_c_tbl[i], 1'b1);
        end

        // OR / AND / reserved
        step(3'b100, 1'b1, 1'b0, 1'b1, 1'b1); chk("or_10", 1'b1, 1'b0, 1'b1);
        step(3'b100, 1'b1, 1'b1, 1'b1, 1'b1); chk("or_11", 1'b1, 1'b0, 1'b1);
        step(3'b100, 1'b0, 1'b0, 1'b1, 1'b1); chk("or_00", 1'b0, 1'b0, 1'b1);
        step(3'b101, 1'b1, 1'b1, 1'b1, 1'b1); chk("and_11", 1'b1, 1'b0, 1'b1);
        step(3'b101, 1'b0, 1'b1, 1'b1, 1'b1); chk("and_01", 1'b0, 1'b0, 1'b1);
        step(3'b101, 1'b1, 1'b0, 1'b1, 1'b1); chk("and_10", 1'b0, 1'b0, 1'b1);
        step(3'b111, 1'b1, 1'b1, 1'b1, 1'b1); chk("rsvd_111_prev", 1'b0, 1'b0, 1'b1);
        step(3'b101, 1'b1, 1'b1, 1'b0, 1'b1); chk("and_pre_rsvd", 1'b1, 1'b0, 1'b1);
        step(3'b110, 1'b1, 1'b1, 1'b1, 1'b1); chk("rsvd_110", 1'b0, 1'b0, 1'b1);
        step(3'b101, 1'b1, 1'b1, 1'b0, 1'b1); chk("and_pre_rsvd2", 1'b1, 1'b0, 1'b1);
        step(3'b111, 1'b1, 1'b1, 1'b1, 1'b1); chk("rsvd_111", 1'b0, 1'b0, 1'b1);

        // Hold when in_valid drops
        step(3'b010, 1'b1, 1'b1, 1'b0, 1'b1); chk("hold_load", 1'b0, 1'b1, 1'b1);
        step(3'b000, 1'b1, 1'b0, 1'b1, 1'b0); chk("hold_1", 1'b0, 1'b1, 1'b0);
        step(3'b001, 1'b0, 1'b0, 1'b0, 1'b0); chk("hold_2", 1'b0, 1'b1, 1'b0);

        // Back-to-back stream, one result per cycle
        step(3'b000, 1'b1, 1'b0, 1'b0, 1'b1); chk("stream_0", 1'b1, 1'b0, 1'b1);
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b1); chk("stream_1", 1'b0, 1'b0, 1'b1);
        step(3'b010, 1'b0, 1'b1, 1'b1, 1'b1); chk("stream_2", 1'b0, 1'b1, 1'b1);
        step(3'b001, 1'b0, 1'b0, 1'b0, 1'b1); chk("stream_3", 1'b1, 1'b0, 1'b1);

        // Asynchronous reset mid-stream, checked before the next edge
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_held", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(3'b000, 1'b1, 1'b0, 1'b0, 1'b1); chk("post_rst_mov", 1'b1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
